// File: rtl/time_set_ctrl.sv
// Operator time-set controller: loads the running time, edits sec/min/hour, commits as three BCD RTC writes.
// Latency: edits visible on *_bcd one cycle after the button pulse; each write holds until wr_ack or timeout.
// Backpressure: wr_req/wr_addr/wr_data held stable until wr_ack; all operator inputs ignored while writing.
module time_set_ctrl #(
    parameter logic [7:0]  ADDR_SEG    = 8'h21,
    parameter logic [7:0]  ADDR_MIN    = 8'h22,
    parameter logic [7:0]  ADDR_HOR    = 8'h23,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       prog_en,
    input  logic       btn_next,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_enter,
    input  logic [5:0] cur_seg,
    input  logic [5:0] cur_min,
    input  logic [4:0] cur_hor,
    input  logic       wr_ack,
    output logic       wr_req,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [1:0] field_sel,
    output logic [7:0] seg_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hor_bcd,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        EDIT_SEG = 4'd1,
        EDIT_MIN = 4'd2,
        EDIT_HOR = 4'd3,
        WR_SEG   = 4'd4,
        GAP1     = 4'd5,
        WR_MIN   = 4'd6,
        GAP2     = 4'd7,
        WR_HOR   = 4'd8,
        FIN      = 4'd9
    } state_t;

    // Wait-counter value at which an unacknowledged write is abandoned.
    localparam logic [7:0] TMO = 8'(ACK_TIMEOUT);

    state_t     state;
    logic       prog_q;
    logic [5:0] seg;
    logic [5:0] min;
    logic [4:0] hor;
    logic [7:0] wait_cnt;
    logic [7:0] wait_nxt;
    logic       prog_rise;

    logic       step_up;
    logic       step_dn;
    logic [5:0] seg_nxt;
    logic [5:0] min_nxt;
    logic [4:0] hor_nxt;
    logic [5:0] hor_w;

    // Binary (0-63) to two-digit BCD; out-of-range loads still render sensibly.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [5:0] rem;
        tens = 4'd0;
        rem  = v;
        if (v >= 6'd60) begin
            tens = 4'd6;
            rem  = v - 6'd60;
        end else if (v >= 6'd50) begin
            tens = 4'd5;
            rem  = v - 6'd50;
        end else if (v >= 6'd40) begin
            tens = 4'd4;
            rem  = v - 6'd40;
        end else if (v >= 6'd30) begin
            tens = 4'd3;
            rem  = v - 6'd30;
        end else if (v >= 6'd20) begin
            tens = 4'd2;
            rem  = v - 6'd20;
        end else if (v >= 6'd10) begin
            tens = 4'd1;
            rem  = v - 6'd10;
        end
        return {tens, rem[3:0]};
    endfunction

    // Increment with wrap to zero past the field maximum.
    function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] vmax);
        return (v >= vmax) ? 6'd0 : v + 6'd1;
    endfunction

    // Decrement with wrap from zero (or an out-of-range value) to the field maximum.
    function automatic logic [5:0] dec_wrap(input logic [5:0] v, input logic [5:0] vmax);
        return (v == 6'd0 || v > vmax) ? vmax : v - 6'd1;
    endfunction

    assign prog_rise = prog_en & ~prog_q;
    assign wait_nxt  = wait_cnt + 8'd1;

    // Display values follow the counters directly.
    assign seg_bcd = to_bcd(seg);
    assign min_bcd = to_bcd(min);
    assign hor_bcd = to_bcd({1'b0, hor});

    // Next counter values for an edit in the current field; up+down together cancel.
    always_comb begin
        step_up = btn_up & ~btn_down;
        step_dn = btn_down & ~btn_up;
        seg_nxt = seg;
        min_nxt = min;
        hor_nxt = hor;
        hor_w   = {1'b0, hor};
        if (state == EDIT_SEG) begin
            if (step_up) seg_nxt = inc_wrap(seg, 6'd59);
            else if (step_dn) seg_nxt = dec_wrap(seg, 6'd59);
        end
        if (state == EDIT_MIN) begin
            if (step_up) min_nxt = inc_wrap(min, 6'd59);
            else if (step_dn) min_nxt = dec_wrap(min, 6'd59);
        end
        if (state == EDIT_HOR) begin
            if (step_up) hor_w = inc_wrap({1'b0, hor}, 6'd23);
            else if (step_dn) hor_w = dec_wrap({1'b0, hor}, 6'd23);
            hor_nxt = hor_w[4:0];
        end
    end

    // Control FSM with registered outputs: edit, then seconds/minutes/hours writes separated by one idle cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            prog_q    <= 1'b0;
            seg       <= 6'd0;
            min       <= 6'd0;
            hor       <= 5'd0;
            wait_cnt  <= 8'd0;
            wr_req    <= 1'b0;
            wr_addr   <= 8'd0;
            wr_data   <= 8'd0;
            field_sel <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            prog_q <= prog_en;
            done   <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (prog_rise) begin
                        seg       <= cur_seg;
                        min       <= cur_min;
                        hor       <= cur_hor;
                        state     <= EDIT_SEG;
                        field_sel <= 2'd1;
                        busy      <= 1'b1;
                    end
                end

                EDIT_SEG, EDIT_MIN, EDIT_HOR: begin
                    if (!prog_en) begin
                        // Operator walked away: drop the edit without writing.
                        state     <= IDLE;
                        field_sel <= 2'd0;
                        busy      <= 1'b0;
                    end else if (btn_enter) begin
                        // Enter outranks every other button pressed in the same cycle.
                        state     <= WR_SEG;
                        field_sel <= 2'd0;
                        wr_req    <= 1'b1;
                        wr_addr   <= ADDR_SEG;
                        wr_data   <= seg_bcd;
                        wait_cnt  <= 8'd0;
                    end else begin
                        seg <= seg_nxt;
                        min <= min_nxt;
                        hor <= hor_nxt;
                        if (btn_next) begin
                            if (state == EDIT_SEG) begin
                                state     <= EDIT_MIN;
                                field_sel <= 2'd2;
                            end else if (state == EDIT_MIN) begin
                                state     <= EDIT_HOR;
                                field_sel <= 2'd3;
                            end else begin
                                state     <= EDIT_SEG;
                                field_sel <= 2'd1;
                            end
                        end
                    end
                end

                WR_SEG, WR_MIN, WR_HOR: begin
                    if (wr_ack) begin
                        wr_req  <= 1'b0;
                        wr_addr <= 8'd0;
                        wr_data <= 8'd0;
                        if (state == WR_SEG) begin
                            state <= GAP1;
                        end else if (state == WR_MIN) begin
                            state <= GAP2;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end else if (wait_nxt == TMO) begin
                        // Bus never answered: abort the whole commit, keep edited values.
                        wr_req   <= 1'b0;
                        wr_addr  <= 8'd0;
                        wr_data  <= 8'd0;
                        err      <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                        wait_cnt <= 8'd0;
                    end else begin
                        wait_cnt <= wait_nxt;
                    end
                end

                GAP1: begin
                    state    <= WR_MIN;
                    wr_req   <= 1'b1;
                    wr_addr  <= ADDR_MIN;
                    wr_data  <= min_bcd;
                    wait_cnt <= 8'd0;
                end

                GAP2: begin
                    state    <= WR_HOR;
                    wr_req   <= 1'b1;
                    wr_addr  <= ADDR_HOR;
                    wr_data  <= hor_bcd;
                    wait_cnt <= 8'd0;
                end

                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    wr_req    <= 1'b0;
                    field_sel <= 2'd0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: table of edit vectors plus directed write, timeout and reset sequences.
// Latency: outputs sampled 1 time unit after each rising clock edge.
// Backpressure: a bench responder returns wr_ack a fixed number of cycles after each request.
module tb_time_set_ctrl;

    logic       clk;
    logic       reset;
    logic       prog_en;
    logic       btn_next;
    logic       btn_up;
    logic       btn_down;
    logic       btn_enter;
    logic [5:0] cur_seg;
    logic [5:0] cur_min;
    logic [4:0] cur_hor;
    logic       wr_ack;
    logic       wr_req;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] field_sel;
    logic [7:0] seg_bcd;
    logic [7:0] min_bcd;
    logic [7:0] hor_bcd;
    logic       busy;
    logic       done;
    logic       err;

    int   checks = 0;
    int   errors = 0;
    logic ack_en = 1'b0;
    int   ack_cnt = 0;

    typedef struct packed {
        logic       prog;
        logic       nxt;
        logic       up;
        logic       dn;
        logic [5:0] cs;
        logic [5:0] cm;
        logic [4:0] ch;
        logic [1:0] ef;
        logic [7:0] es;
        logic [7:0] em;
        logic [7:0] eh;
        logic       eb;
    } vec_t;

    vec_t tbl[22];

    time_set_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .prog_en   (prog_en),
        .btn_next  (btn_next),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_enter (btn_enter),
        .cur_seg   (cur_seg),
        .cur_min   (cur_min),
        .cur_hor   (cur_hor),
        .wr_ack    (wr_ack),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .field_sel (field_sel),
        .seg_bcd   (seg_bcd),
        .min_bcd   (min_bcd),
        .hor_bcd   (hor_bcd),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bus responder: raises wr_ack for one cycle, three samples into each request.
    initial begin
        wr_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ack_en && wr_req && !wr_ack) begin
                if (ack_cnt == 2) begin
                    wr_ack  = 1'b1;
                    ack_cnt = 0;
                end else begin
                    ack_cnt++;
                end
            end else begin
                wr_ack  = 1'b0;
                ack_cnt = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input int p, input int n, input int u, input int d,
                                input int cs, input int cm, input int ch,
                                input int ef, input int es, input int em, input int eh, input int eb);
        vec_t v;
        v.prog = 1'(p);
        v.nxt  = 1'(n);
        v.up   = 1'(u);
        v.dn   = 1'(d);
        v.cs   = 6'(cs);
        v.cm   = 6'(cm);
        v.ch   = 5'(ch);
        v.ef   = 2'(ef);
        v.es   = 8'(es);
        v.em   = 8'(em);
        v.eh   = 8'(eh);
        v.eb   = 1'(eb);
        return v;
    endfunction

    initial begin
        logic [7:0] a[3];
        logic [7:0] d[3];
        int         hi[3];
        int         gaps[2];
        int         nw;
        int         ndone;
        int         gap_run;
        int         stable_err;
        logic       prev_req;
        bit         fin;
        int         nhi;
        int         nerr;
        int         after;
        int         late_req;
        bit         seen;
        logic       req_at_err;
        logic       busy_at_err;
        bit         found;

        //       prog nxt up dn  cur(s,m,h)   fsel  seg    min    hor  busy
        tbl[0]  = mk(1, 0, 0, 0, 45, 12, 9,  1, 'h45, 'h12, 'h09, 1);
        tbl[1]  = mk(1, 0, 1, 0, 45, 12, 9,  1, 'h46, 'h12, 'h09, 1);
        tbl[2]  = mk(1, 0, 0, 1, 45, 12, 9,  1, 'h45, 'h12, 'h09, 1);
        tbl[3]  = mk(1, 0, 1, 1, 45, 12, 9,  1, 'h45, 'h12, 'h09, 1);
        tbl[4]  = mk(1, 1, 0, 0, 45, 12, 9,  2, 'h45, 'h12, 'h09, 1);
        tbl[5]  = mk(1, 0, 0, 1, 45, 12, 9,  2, 'h45, 'h11, 'h09, 1);
        tbl[6]  = mk(1, 1, 1, 0, 45, 12, 9,  3, 'h45, 'h12, 'h09, 1);
        tbl[7]  = mk(1, 0, 0, 1, 45, 12, 9,  3, 'h45, 'h12, 'h08, 1);
        tbl[8]  = mk(1, 1, 0, 0, 45, 12, 9,  1, 'h45, 'h12, 'h08, 1);
        tbl[9]  = mk(1, 1, 0, 0, 45, 12, 9,  2, 'h45, 'h12, 'h08, 1);
        tbl[10] = mk(0, 0, 1, 0, 45, 12, 9,  0, 'h45, 'h12, 'h08, 0);
        tbl[11] = mk(0, 0, 1, 0, 45, 12, 9,  0, 'h45, 'h12, 'h08, 0);
        tbl[12] = mk(1, 0, 0, 0, 59, 0, 0,   1, 'h59, 'h00, 'h00, 1);
        tbl[13] = mk(1, 0, 1, 0, 59, 0, 0,   1, 'h00, 'h00, 'h00, 1);
        tbl[14] = mk(1, 0, 0, 1, 59, 0, 0,   1, 'h59, 'h00, 'h00, 1);
        tbl[15] = mk(1, 1, 0, 0, 59, 0, 0,   2, 'h59, 'h00, 'h00, 1);
        tbl[16] = mk(1, 0, 0, 1, 59, 0, 0,   2, 'h59, 'h59, 'h00, 1);
        tbl[17] = mk(1, 0, 1, 0, 59, 0, 0,   2, 'h59, 'h00, 'h00, 1);
        tbl[18] = mk(1, 1, 0, 0, 59, 0, 0,   3, 'h59, 'h00, 'h00, 1);
        tbl[19] = mk(1, 0, 0, 1, 59, 0, 0,   3, 'h59, 'h00, 'h23, 1);
        tbl[20] = mk(1, 0, 1, 0, 59, 0, 0,   3, 'h59, 'h00, 'h00, 1);
        tbl[21] = mk(1, 1, 0, 1, 59, 0, 0,   1, 'h59, 'h00, 'h23, 1);

        reset     = 1'b0;
        prog_en   = 1'b0;
        btn_next  = 1'b0;
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        btn_enter = 1'b0;
        cur_seg   = 6'd0;
        cur_min   = 6'd0;
        cur_hor   = 5'd0;

        // Reset state
        #2;
        chk("rst_wr_req", 32'(wr_req), 32'd0);
        chk("rst_field", 32'(field_sel), 32'd0);
        chk("rst_seg", 32'(seg_bcd), 32'd0);
        chk("rst_min", 32'(min_bcd), 32'd0);
        chk("rst_hor", 32'(hor_bcd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", 32'({done, err, wr_addr, wr_data}), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();

        // Edit vectors
        for (int i = 0; i < 22; i++) begin
            prog_en  = tbl[i].prog;
            btn_next = tbl[i].nxt;
            btn_up   = tbl[i].up;
            btn_down = tbl[i].dn;
            cur_seg  = tbl[i].cs;
            cur_min  = tbl[i].cm;
            cur_hor  = tbl[i].ch;
            tick();
            chk($sformatf("vec%0d_field", i), 32'(field_sel), 32'(tbl[i].ef));
            chk($sformatf("vec%0d_seg", i), 32'(seg_bcd), 32'(tbl[i].es));
            chk($sformatf("vec%0d_min", i), 32'(min_bcd), 32'(tbl[i].em));
            chk($sformatf("vec%0d_hor", i), 32'(hor_bcd), 32'(tbl[i].eh));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].eb));
            chk($sformatf("vec%0d_wr_req", i), 32'(wr_req), 32'd0);
        end
        btn_next = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;

        // Full commit of 07:30:18 with buttons and prog_en wiggled during the writes
        prog_en = 1'b0;
        tick();
        prog_en = 1'b1;
        cur_seg = 6'd7;
        cur_min = 6'd30;
        cur_hor = 5'd18;
        tick();
        chk("commit_load_field", 32'(field_sel), 32'd1);
        ack_en    = 1'b1;
        btn_enter = 1'b1;
        btn_up    = 1'b1;
        tick();
        btn_enter = 1'b0;
        chk("commit_field0", 32'(field_sel), 32'd0);
        chk("commit_busy", 32'(busy), 32'd1);
        nw = 0;
        ndone = 0;
        gap_run = 0;
        stable_err = 0;
        prev_req = 1'b0;
        fin = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a[k] = 8'd0;
            d[k] = 8'd0;
            hi[k] = 0;
        end
        gaps[0] = 0;
        gaps[1] = 0;
        btn_next = 1'b1;
        for (int c = 0; c < 80 && !fin; c++) begin
            if (wr_req) begin
                if (!prev_req) begin
                    if (nw < 3) begin
                        a[nw] = wr_addr;
                        d[nw] = wr_data;
                        if (nw > 0) gaps[nw-1] = gap_run;
                    end
                    nw++;
                end
                if (nw <= 3) begin
                    hi[nw-1]++;
                    if (wr_addr !== a[nw-1] || wr_data !== d[nw-1]) stable_err++;
                end
                if (wr_addr == 8'h23) prog_en = ~prog_en;
            end else begin
                gap_run = prev_req ? 1 : gap_run + 1;
            end
            if (done) begin
                ndone++;
                fin = 1'b1;
            end
            prev_req = wr_req;
            tick();
        end
        btn_next = 1'b0;
        btn_up   = 1'b0;
        prog_en  = 1'b0;
        chk("seq_writes", 32'(nw), 32'd3);
        chk("seq_addr0", 32'(a[0]), 32'h21);
        chk("seq_data0", 32'(d[0]), 32'h07);
        chk("seq_addr1", 32'(a[1]), 32'h22);
        chk("seq_data1", 32'(d[1]), 32'h30);
        chk("seq_addr2", 32'(a[2]), 32'h23);
        chk("seq_data2", 32'(d[2]), 32'h18);
        chk("seq_hold0", 32'(hi[0]), 32'd3);
        chk("seq_hold1", 32'(hi[1]), 32'd3);
        chk("seq_hold2", 32'(hi[2]), 32'd3);
        chk("seq_gap1", 32'(gaps[0]), 32'd1);
        chk("seq_gap2", 32'(gaps[1]), 32'd1);
        chk("seq_stable", 32'(stable_err), 32'd0);
        chk("seq_done_cnt", 32'(ndone), 32'd1);
        chk("seq_done_pulse", 32'(done), 32'd0);
        chk("seq_busy_end", 32'(busy), 32'd0);
        tick();
        tick();
        chk("seq_idle_req", 32'(wr_req), 32'd0);
        chk("seq_idle_field", 32'(field_sel), 32'd0);
        ack_en = 1'b0;

        // Ack never arrives: abort after ACK_TIMEOUT request cycles
        prog_en = 1'b1;
        cur_seg = 6'd1;
        cur_min = 6'd2;
        cur_hor = 5'd3;
        tick();
        btn_enter = 1'b1;
        tick();
        btn_enter = 1'b0;
        nhi = 0;
        nerr = 0;
        after = 0;
        late_req = 0;
        seen = 1'b0;
        req_at_err = 1'b1;
        busy_at_err = 1'b1;
        for (int c = 0; c < 400 && after < 10; c++) begin
            if (wr_req) begin
                if (seen) late_req++;
                else nhi++;
            end
            if (err) begin
                if (!seen) begin
                    req_at_err = wr_req;
                    busy_at_err = busy;
                end
                nerr++;
                seen = 1'b1;
            end
            if (seen) after++;
            tick();
        end
        chk("tmo_req_cycles", 32'(nhi), 32'd255);
        chk("tmo_err_pulses", 32'(nerr), 32'd1);
        chk("tmo_req_at_err", 32'(req_at_err), 32'd0);
        chk("tmo_busy_at_err", 32'(busy_at_err), 32'd0);
        chk("tmo_no_more_writes", 32'(late_req), 32'd0);
        chk("tmo_kept_seg", 32'(seg_bcd), 32'h01);
        chk("tmo_kept_hor", 32'(hor_bcd), 32'h03);

        // Asynchronous reset in the middle of the minutes write
        prog_en = 1'b0;
        tick();
        prog_en = 1'b1;
        cur_seg = 6'd7;
        cur_min = 6'd30;
        cur_hor = 5'd18;
        tick();
        ack_en = 1'b1;
        btn_enter = 1'b1;
        tick();
        btn_enter = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (wr_req && wr_addr == 8'h22) found = 1'b1;
            else tick();
        end
        chk("arst_reached_wr_min", 32'(found), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_wr_req", 32'(wr_req), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_bus", 32'({wr_addr, wr_data}), 32'd0);
        chk("arst_bcd", 32'({seg_bcd, min_bcd, hor_bcd}), 32'd0);
        chk("arst_misc", 32'({field_sel, done, err}), 32'd0);
        prog_en = 1'b0;
        ack_en = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tick();
        tick();
        chk("arst_idle_req", 32'(wr_req), 32'd0);
        chk("arst_idle_busy", 32'(busy), 32'd0);
        chk("arst_idle_field", 32'(field_sel), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Operator time-set controller for the RTC clock design.
- Loads the current time into editable binary counters: seconds 0-59, minutes 0-59, hours 0-23.
- Steps field selection and applies up/down edits with wrap-around.
- On commit, sequences three BCD register writes to the RTC bus interface over a req/ack handshake. Also drives field-select and BCD values for the display.

Parameters:
- ADDR_SEG, 8'h21: RTC seconds register address.
- ADDR_MIN, 8'h22: RTC minutes register address.
- ADDR_HOR, 8'h23: RTC hours register address.
- ACK_TIMEOUT, 255: maximum cycles wr_req may wait for wr_ack before abort (1-255).

Ports:
- clk, input, 1: single system clock, rising edge.
- reset, input, 1: asynchronous active-low reset.
- prog_en, input, 1: level; high requests programming mode.
- btn_next, input, 1: one-cycle pulse, pre-debounced; advances the edited field.
- btn_up, input, 1: one-cycle pulse; increments the selected field.
- btn_down, input, 1: one-cycle pulse; decrements the selected field.
- btn_enter, input, 1: one-cycle pulse; commits the time to the RTC.
- cur_seg, input, 6: current seconds, binary.
- cur_min, input, 6: current minutes, binary.
- cur_hor, input, 5: current hours, binary.
- wr_ack, input, 1: bus interface write-complete acknowledge.
- wr_req, output, 1: write request.
- wr_addr, output, 8: register address, valid while wr_req=1.
- wr_data, output, 8: BCD data, valid while wr_req=1.
- field_sel, output, 2: 0=none, 1=seconds, 2=minutes, 3=hours.
- seg_bcd, output, 8: edited seconds in BCD.
- min_bcd, output, 8: edited minutes in BCD.
- hor_bcd, output, 8: edited hours in BCD.
- busy, output, 1: high in any state except IDLE.
- done, output, 1: one-cycle pulse when all three writes complete.
- err, output, 1: one-cycle pulse on ack timeout.

Behaviour:
- Reset values: all outputs 0, counters 0, state IDLE. Reset is asynchronous at any time, including mid-write; wr_req drops immediately.
- States: IDLE, EDIT_SEG, EDIT_MIN, EDIT_HOR, WR_SEG, GAP1, WR_MIN, GAP2, WR_HOR, FIN.
- IDLE:
  - Leaves on a rising edge of prog_en; the edge is detected with a registered copy.
  - On that edge: load seg=cur_seg, min=cur_min, hor=cur_hor, and go to EDIT_SEG next cycle.
- EDIT states:
  - field_sel = 1/2/3 respectively.
  - btn_next cycles SEG->MIN->HOR->SEG.
  - btn_up: +1 on the selected counter. 59->0 for seg/min; 23->0 for hours.
  - btn_down: -1 on the selected counter. 0->59 for seg/min; 0->23 for hours.
  - btn_up and btn_down in the same cycle: no change.
  - btn_next together with up/down: the edit applies to the current field, then the field advances.
  - Counter update is visible in the *_bcd outputs the cycle after the pulse.
  - prog_en low: abandon the edit, go to IDLE, no writes.
  - btn_enter: go to WR_SEG. btn_enter takes priority over all other buttons in the same cycle.
- BCD conversion: combinational from the counters; tens in [7:4], units in [3:0]; true value with no offset (e.g. 37 -> 8'h37). Hours upper bits [7:6] are always 0.
- Write sequence (wr_req is registered):
  - WR_x holds wr_req=1, wr_addr=ADDR_x, wr_data=x_bcd stable until wr_ack=1 is sampled.
  - The cycle after ack, wr_req=0 for exactly one cycle (GAP), then the next write.
  - Order is fixed: seconds, minutes, hours.
  - wr_ack sampled outside WR states is ignored.
  - After the hours ack: go to FIN, done=1 for one cycle, then IDLE.
- During WR/GAP/FIN all buttons and prog_en are ignored, so the sequence always completes or times out.
- Timeout:
  - An 8-bit wait counter clears on entering each WR state and increments each cycle without ack.
  - When the counter reaches ACK_TIMEOUT: wr_req=0, err=1 for one cycle, go to IDLE. Counters are kept.
- After return to IDLE, prog_en must go low then high again to re-enter edit.
- field_sel=0 in IDLE, WR, GAP and FIN states.

Test Plan:
- Reset low mid-WR_MIN with wr_req=1 -> wr_req, busy and all outputs 0 immediately; state IDLE after release.
- prog_en 0->1 with cur=(45,12,9) -> next cycle field_sel=1, seg_bcd=8'h45, min_bcd=8'h12, hor_bcd=8'h09, busy=1.
- Wrap cases:
  - In EDIT_SEG at 59, btn_up -> seg_bcd=8'h00.
  - btn_next twice to hours at 0, btn_down -> hor_bcd=8'h23.
  - btn_up and btn_down together -> unchanged.
- btn_enter with (07,30,18) and wr_ack returned 3 cycles after each request -> writes (21,07), (22,30), (23,18) in order; wr_req low exactly one cycle between writes; done pulses once.
- wr_ack held 0 in WR_SEG -> err pulses after 255 request cycles; wr_req=0; busy=0; no further writes.
- prog_en dropped in EDIT_MIN -> IDLE with no wr_req. prog_en toggled during WR_HOR -> sequence completes with done.
